// File: rtl/rv32_mem_pkg.sv
// Shared types and widths for the rv32 data-memory responder.
package rv32_mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

endpackage

// File: rtl/rv32_byte_ram.sv
// Word RAM with a byte-enabled synchronous write port and an asynchronous read port.
module rv32_byte_ram
    import rv32_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10,
    parameter string       INIT_FILE   = ""
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [BE_W-1:0] be,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/rv32_dmem_responder.sv
// Single-outstanding load/store responder: accept, wait LATENCY cycles, commit, respond.
module rv32_dmem_responder
    import rv32_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int unsigned CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [XLEN-3:0]   widx_q, widx_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept, commit;
    logic              cmd_we, cmd_err;
    logic [XLEN-3:0]   cmd_widx;
    logic [XLEN-1:0]   cmd_wdata;
    logic [BE_W-1:0]   cmd_be;
    logic              ram_we;
    logic [XLEN-1:0]   ram_rdata;
    logic [1:0]        unused_addr_lsb;

    assign unused_addr_lsb = req_addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            widx_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            widx_q      <= widx_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = (LATENCY == 0) ? RESP : WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = rsp_valid_q;
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
    end

    assign accept = (state_q == IDLE) && req_valid;
    // The commit edge is the RESP entry edge; with LATENCY==0 it is also the accept edge,
    // so the command is taken straight from the request inputs in that case.
    assign commit = (state_d == RESP) && (state_q != RESP);

    always_comb begin
        if (state_q == IDLE) begin
            cmd_we    = req_we;
            cmd_widx  = req_addr[XLEN-1:2];
            cmd_wdata = req_wdata;
            cmd_be    = req_be;
        end else begin
            cmd_we    = we_q;
            cmd_widx  = widx_q;
            cmd_wdata = wdata_q;
            cmd_be    = be_q;
        end
        cmd_err = ({2'b00, cmd_widx} >= DEPTH_WORDS) || (cmd_we && (cmd_be == '0));
        ram_we  = commit && cmd_we && !cmd_err && !reset;
    end

    always_comb begin
        we_d        = we_q;
        widx_d      = widx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            we_d    = req_we;
            widx_d  = req_addr[XLEN-1:2];
            wdata_d = req_wdata;
            be_d    = req_be;
        end
        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = cmd_err;
            rsp_rdata_d = (cmd_we || cmd_err) ? '0 : ram_rdata;
        end else if ((state_q == RESP) && rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
        end
    end

    rv32_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (cmd_widx[AW-1:0]),
        .wdata (cmd_wdata),
        .be    (cmd_be),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Directed and randomized bench for rv32_dmem_responder (LATENCY=2 and LATENCY=0 builds).
module tb_rv32_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam int unsigned NW    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] mem_m [NW];

    always #5 clk = ~clk;

    rv32_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    rv32_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_z (
        .clk       (clk),
        .reset     (reset),
        .req_valid (z_req_valid),
        .req_ready (z_req_ready),
        .req_we    (z_req_we),
        .req_addr  (z_req_addr),
        .req_wdata (z_req_wdata),
        .req_be    (z_req_be),
        .rsp_valid (z_rsp_valid),
        .rsp_ready (z_rsp_ready),
        .rsp_rdata (z_rsp_rdata),
        .rsp_err   (z_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction on the LATENCY=2 instance, checked against mem_m.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int stall, input logic poke);
        logic        err;
        logic [31:0] exp_rd;
        logic [31:0] w;
        int          n;
        err    = ((addr >> 2) >= DEPTH) || (we && (be == 4'h0));
        exp_rd = (we || err) ? 32'h0 : mem_m[addr[5:2]];
        @(negedge clk);
        chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = (stall == 0);
        @(posedge clk);
        #1;
        // Junk request while busy: must be ignored.
        req_valid = poke;
        req_we    = ~we;
        req_addr  = {$urandom_range(0, NW - 1), 2'b00};
        req_wdata = $urandom;
        req_be    = 4'hF;
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            chk("wait_req_ready", {31'b0, req_ready}, 32'd0);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", n, LAT + 1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, err});
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_rdata", rsp_rdata, exp_rd);
            chk("stall_err", {31'b0, rsp_err}, {31'b0, err});
            chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("done_valid", {31'b0, rsp_valid}, 32'd0);
        chk("done_rdata", rsp_rdata, 32'h0);
        chk("done_err", {31'b0, rsp_err}, 32'd0);
        chk("done_req_ready", {31'b0, req_ready}, 32'd1);
        if (we && !err) begin
            w = mem_m[addr[5:2]];
            for (int i = 0; i < 4; i++) begin
                if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
            end
            mem_m[addr[5:2]] = w;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          accepts;
        logic [31:0] a;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0;
        z_req_be = '0; z_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < int'(NW); i++) do_req(1'b1, i * 4, $urandom, 4'hF, 0, 1'b0);

        // Full-word store then load.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
        // Byte-lane store merges into the existing word.
        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0);
        do_req(1'b1, 32'h20, 32'h0000AA00, 4'b0010, 0, 1'b0);
        do_req(1'b0, 32'h23, 32'h0, 4'h0, 0, 1'b0);
        chk("byte_merge_model", mem_m[8], 32'h1122AA44);
        // Backpressure with a competing request.
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 5, 1'b1);
        // Errors.
        do_req(1'b0, 4 * DEPTH, 32'h0, 4'hF, 0, 1'b0);
        do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
        do_req(1'b1, 32'hFFFF_FFFC, 32'h12345678, 4'hF, 0, 1'b0);

        // Reset while a store waits: it must never be written.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
        req_wdata = 32'h0BADF00D; req_be = 4'hF; rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'h0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
        chk("midrst_old_word", mem_m[4], 32'hDEADBEEF);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) == 0) a = 4 * DEPTH + ($urandom_range(0, 255) << 2);
            else a = {$urandom_range(0, NW - 1), $urandom_range(0, 3)};
            do_req($urandom_range(0, 1), a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // LATENCY=0 build: store, then back-to-back loads with rsp_ready held high.
        @(negedge clk);
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h40;
        z_req_wdata = 32'hCAFEF00D; z_req_be = 4'hF; z_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("z_store_valid", {31'b0, z_rsp_valid}, 32'd1);
        chk("z_store_rdata", z_rsp_rdata, 32'h0);
        chk("z_store_err", {31'b0, z_rsp_err}, 32'd0);
        chk("z_store_req_ready", {31'b0, z_req_ready}, 32'd0);
        z_req_we = 1'b0;
        accepts = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("z_idle_req_ready", {31'b0, z_req_ready}, 32'd1);
                chk("z_idle_valid", {31'b0, z_rsp_valid}, 32'd0);
            end else begin
                chk("z_rsp_valid", {31'b0, z_rsp_valid}, 32'd1);
                chk("z_rsp_rdata", z_rsp_rdata, 32'hCAFEF00D);
                chk("z_rsp_req_ready", {31'b0, z_req_ready}, 32'd0);
            end
            accepts += int'(z_req_ready);
        end
        chk("z_accepts", accepts, 4);
        z_req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
